dual_issue_ctrl: RTL and testbench
==================================

# dual_issue_ctrl

Instruction issue controller for the dual-issue superscalar pipeline. It buffers fetched instruction pairs in a small circular queue and presents the two oldest entries to the decode stage each cycle. From decode's pairing-hazard verdict, halt flags and the backend stall, it decides whether to issue 0, 1 or 2 instructions. It also handles pipeline flushes, terminal halt, and two issue performance counters.

## Interface
Parameters:
- DEPTH, 4: queue entries (instr + pc each); power of two, ≥4
- Ports (clock and reset first):
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- fetch_valid  in  1  fetch offers a pair this cycle
- fetch_instr1  in  32  older fetched instruction
- fetch_instr2  in  32  younger fetched instruction
- fetch_pc  in  32  pc of fetch_instr1; fetch_instr2 is at fetch_pc+4
- fetch_ready  out  1  queue accepts a pair this cycle
- flush  in  1  discard all queued entries (branch/jalr redirect)
- stall  in  1  backend cannot accept issue this cycle
- pair_conflict  in  1  decode's single-issue verdict for the presented head pair
- halt1  in  1  presented issue_instr1 decodes as halt
- issue_instr1, issue_instr2  out  32  head entry, head+1 entry
- issue_pc1, issue_pc2  out  32  their pcs
- issue_valid1, issue_valid2  out  1  slot issues this cycle
- halted  out  1  halt has issued; controller is frozen
- issued_cnt  out  32  total instructions issued
- single_cnt  out  32  cycles with exactly one instruction issued

## Operation
- Storage: DEPTH × {instr, pc}, head/tail pointers of width log2(DEPTH), count of width log2(DEPTH)+1. Pointers wrap modulo DEPTH.
- Push: when fetch_valid & fetch_ready, write instr1/pc at tail and instr2/pc+4 at tail+1. tail += 2.
- fetch_ready = !rst & state==RUN & !flush & (DEPTH − count ≥ 2). The registered count is used and same-cycle pops are not credited.
- Presentation: issue_instr1/pc1 = entry[head], issue_instr2/pc2 = entry[head+1], always driven from registered state. Unoccupied slots are don't-care.
- issue_valid1 = state==RUN & !flush & !stall & count≥1.
- issue_valid2 = issue_valid1 & count≥2 & !pair_conflict & !halt1.
- Pop: head += valid1+valid2 and count updates by pushes − pops. Simultaneous push and pop in one cycle is supported.
- State machine: RUN → HALTED when issue_valid1 & halt1. HALTED is left only by rst. In HALTED, the issue valids and fetch_ready are 0, the queue is frozen, and halted=1.
- Flush: head, tail and count ← 0. The same-cycle push is dropped and no issue occurs. A flush in HALTED clears the queue but the state stays HALTED.
- Counters: issued_cnt += valid1+valid2 and single_cnt += (valid1 & !valid2). Both wrap at 2^32 and hold during flush, stall and HALTED.
- Reset: head, tail, count, issued_cnt and single_cnt ← 0; state ← RUN. During the rst cycle all outputs are 0 (valids, fetch_ready, halted, counters).

## Timing
- Combinational paths: pair_conflict, halt1, stall and flush → issue_valid*. This is a one-cycle loop through decode with no registered break. pair_conflict/halt1 must depend only on issue_instr*, which are registered, so the loop is acyclic.
- Latency: a pair accepted in cycle N (queue empty) is presented and issuable in cycle N+1.
- Throughput: a sustained 2 instructions/cycle with DEPTH≥4 and no conflicts.
- Boundaries:
  - count=DEPTH−1 → fetch_ready=0.
  - count=1 → at most a single issue; instr2 waits for the next pair.
  - Pointer wrap from DEPTH−1 to 0 must not corrupt order.
  - flush with stall → flush wins.
  - rst overrides everything, including flush and fetch.

## Test plan
- Reset, then push pairs (pc 0x0, 0x8, 0x10) with pair_conflict=0, stall=0 → 2 issues/cycle from cycle after first push; pcs in order 0,4,8,…; issued_cnt=6, single_cnt=0.
- Hold pair_conflict=1 for the head pair at pc 0x0 → cycle issues only pc 0; next cycle head is pc 4 with pc 8 paired; single_cnt=1.
- Fill queue with fetch_valid=1 and stall=1 → fetch_ready drops at count=4 (DEPTH=4); release stall → order preserved across pointer wrap, no entry lost or duplicated.
- Queue holds 3 entries, assert flush concurrent with fetch_valid and stall=0 → no issue, push dropped, count=0 next cycle, counters unchanged.
- halt1=1 on head at pc 0x20 with 2 entries queued → only valid1 issues, halted=1 next cycle, all valids and fetch_ready stay 0 thereafter; rst restores RUN with counters 0.
- rst asserted mid-stream (count=2, both valid) → same cycle all outputs 0; next cycle count=0, fetch_ready=1.

Source files
------------

// File: rtl/dual_issue_ctrl_if.sv
// Bundle of the fetch, decode-feedback and issue signals of dual_issue_ctrl.
// master: fetch/decode/backend side; slave: the issue controller.
interface dual_issue_ctrl_if;
    logic        fetch_valid;
    logic [31:0] fetch_instr1;
    logic [31:0] fetch_instr2;
    logic [31:0] fetch_pc;
    logic        fetch_ready;
    logic        flush;
    logic        stall;
    logic        pair_conflict;
    logic        halt1;
    logic [31:0] issue_instr1;
    logic [31:0] issue_instr2;
    logic [31:0] issue_pc1;
    logic [31:0] issue_pc2;
    logic        issue_valid1;
    logic        issue_valid2;
    logic        halted;
    logic [31:0] issued_cnt;
    logic [31:0] single_cnt;

    modport master (
        output fetch_valid, fetch_instr1, fetch_instr2, fetch_pc,
        output flush, stall, pair_conflict, halt1,
        input  fetch_ready,
        input  issue_instr1, issue_instr2, issue_pc1, issue_pc2,
        input  issue_valid1, issue_valid2, halted, issued_cnt, single_cnt
    );

    modport slave (
        input  fetch_valid, fetch_instr1, fetch_instr2, fetch_pc,
        input  flush, stall, pair_conflict, halt1,
        output fetch_ready,
        output issue_instr1, issue_instr2, issue_pc1, issue_pc2,
        output issue_valid1, issue_valid2, halted, issued_cnt, single_cnt
    );
endinterface

// File: rtl/dual_issue_ctrl.sv
// Dual-issue instruction issue controller: circular queue of fetched pairs,
// presents the two oldest entries and issues 0/1/2 per cycle.
//
// state      | meaning
// ST_RUN     | accepting fetch pairs and issuing
// ST_HALTED  | halt instruction has issued; queue and counters frozen until rst
module dual_issue_ctrl #(
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    dual_issue_ctrl_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);
    localparam logic [PW:0] TWO_C   = (PW+1)'(2);

    typedef enum logic {ST_RUN, ST_HALTED} state_t;

    state_t        state_q, state_d;
    logic [31:0]   instr_q [DEPTH];
    logic [31:0]   pc_q    [DEPTH];
    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [PW-1:0] head_p1, tail_p1;
    logic [PW:0]   count_q, count_d, free_w;
    logic [31:0]   issued_q, issued_d, single_q, single_d;
    logic          run_w, ready_w, push_w, valid1_w, valid2_w;
    logic [1:0]    pop_w;

    // Handshake and issue decisions; decode feedback feeds the valids directly.
    always_comb begin
        run_w    = (state_q == ST_RUN);
        free_w   = DEPTH_C - count_q;
        ready_w  = !rst_i && run_w && !bus.flush && (free_w >= TWO_C);
        push_w   = bus.fetch_valid && ready_w;
        valid1_w = !rst_i && run_w && !bus.flush && !bus.stall && (count_q != '0);
        valid2_w = valid1_w && (count_q >= TWO_C) && !bus.pair_conflict && !bus.halt1;
        pop_w    = {1'b0, valid1_w} + {1'b0, valid2_w};
        head_p1  = head_q + PW'(1);
        tail_p1  = tail_q + PW'(1);
    end

    // Next-state for the FSM, pointers and counters.
    always_comb begin
        state_d  = state_q;
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q;
        issued_d = issued_q;
        single_d = single_q;
        if (bus.flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d   = head_q + PW'(pop_w);
            tail_d   = push_w ? tail_q + PW'(2) : tail_q;
            count_d  = count_q + (push_w ? TWO_C : '0) - (PW+1)'(pop_w);
            issued_d = issued_q + 32'(pop_w);
            single_d = single_q + 32'(valid1_w && !valid2_w);
            if (valid1_w && bus.halt1) begin
                state_d = ST_HALTED;
            end
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_RUN;
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            issued_q <= '0;
            single_q <= '0;
        end else begin
            state_q  <= state_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            issued_q <= issued_d;
            single_q <= single_d;
        end
    end

    // Queue storage: a pair occupies tail and tail+1.
    always_ff @(posedge clk_i) begin
        if (push_w) begin
            instr_q[tail_q]  <= bus.fetch_instr1;
            pc_q[tail_q]     <= bus.fetch_pc;
            instr_q[tail_p1] <= bus.fetch_instr2;
            pc_q[tail_p1]    <= bus.fetch_pc + 32'd4;
        end
    end

    assign bus.fetch_ready  = ready_w;
    assign bus.issue_valid1 = valid1_w;
    assign bus.issue_valid2 = valid2_w;
    assign bus.issue_instr1 = instr_q[head_q];
    assign bus.issue_pc1    = pc_q[head_q];
    assign bus.issue_instr2 = instr_q[head_p1];
    assign bus.issue_pc2    = pc_q[head_p1];
    assign bus.halted       = !rst_i && (state_q == ST_HALTED);
    assign bus.issued_cnt   = rst_i ? '0 : issued_q;
    assign bus.single_cnt   = rst_i ? '0 : single_q;
endmodule

// File: tb/tb_dual_issue_ctrl.sv
// Bench for dual_issue_ctrl: directed scenarios plus a randomized run,
// all checked against a queue-based reference model.
module tb_dual_issue_ctrl;
    localparam int DEPTH = 4;
    localparam logic [31:0] HALT_OP = 32'h0000_0073;

    logic clk_i = 1'b0;
    logic rst_i;
    dual_issue_ctrl_if bus();

    dual_issue_ctrl #(.DEPTH(DEPTH)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    ent_t        mq[$];
    bit          m_halted;
    logic [31:0] m_issued, m_single;
    logic        exp_ready, exp_v1, exp_v2;
    int          checks = 0;
    int          errors = 0;

    function automatic logic [31:0] ins(input logic [31:0] pc);
        return 32'hA000_0000 | pc;
    endfunction

    function automatic void model_eval();
        int sz;
        sz = mq.size();
        exp_ready = !rst_i && !m_halted && !bus.flush && ((DEPTH - sz) >= 2);
        exp_v1    = !rst_i && !m_halted && !bus.flush && !bus.stall && (sz >= 1);
        exp_v2    = exp_v1 && (sz >= 2) && !bus.pair_conflict && !bus.halt1;
    endfunction

    function automatic void model_update();
        int n;
        if (rst_i) begin
            mq.delete();
            m_halted = 0;
            m_issued = '0;
            m_single = '0;
        end else if (bus.flush) begin
            mq.delete();
        end else begin
            n = int'(exp_v1) + int'(exp_v2);
            repeat (n) void'(mq.pop_front());
            if (bus.fetch_valid && exp_ready) begin
                mq.push_back(ent_t'{bus.fetch_instr1, bus.fetch_pc});
                mq.push_back(ent_t'{bus.fetch_instr2, bus.fetch_pc + 32'd4});
            end
            m_issued = m_issued + 32'(n);
            if (exp_v1 && !exp_v2) m_single = m_single + 32'd1;
            if (exp_v1 && bus.halt1) m_halted = 1;
        end
    endfunction

    task automatic drive(input logic r, input logic fv, input logic [31:0] i1,
                         input logic [31:0] i2, input logic [31:0] pc,
                         input logic fl, input logic st, input logic cf, input logic h);
        rst_i             = r;
        bus.fetch_valid   = fv;
        bus.fetch_instr1  = i1;
        bus.fetch_instr2  = i2;
        bus.fetch_pc      = pc;
        bus.flush         = fl;
        bus.stall         = st;
        bus.pair_conflict = cf;
        bus.halt1         = h;
        #1;
        model_eval();
    endtask

    task automatic tick();
        @(posedge clk_i);
        model_update();
        @(negedge clk_i);
    endtask

    task automatic idle();
        drive(0, 0, '0, '0, '0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        drive(1, 0, '0, '0, '0, 0, 0, 0, 0);
        tick();
    endtask

    task automatic test_reset();
        drive(1, 1, ins(0), ins(4), 32'h0, 0, 0, 0, 0);
        checks++; if (bus.fetch_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", bus.fetch_ready); end
        checks++; if (bus.issue_valid1 !== 1'b0) begin errors++; $display("FAIL reset_v1 got %b want 0", bus.issue_valid1); end
        checks++; if (bus.halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %b want 0", bus.halted); end
        checks++; if (bus.issued_cnt !== 32'd0) begin errors++; $display("FAIL reset_issued got %0d want 0", bus.issued_cnt); end
        checks++; if (bus.single_cnt !== 32'd0) begin errors++; $display("FAIL reset_single got %0d want 0", bus.single_cnt); end
        tick();
        tick();
        idle();
        checks++; if (bus.fetch_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready got %b want 1", bus.fetch_ready); end
        checks++; if (bus.issue_valid1 !== 1'b0) begin errors++; $display("FAIL post_reset_v1 got %b want 0", bus.issue_valid1); end
        tick();
    endtask

    task automatic test_throughput();
        logic [31:0] b;
        do_reset();
        drive(0, 1, ins(0), ins(4), 32'h0, 0, 0, 0, 0);
        checks++; if (bus.issue_valid1 !== 1'b0) begin errors++; $display("FAIL tp_empty_v1 got %b want 0", bus.issue_valid1); end
        tick();
        for (int k = 0; k < 3; k++) begin
            b = 32'(8 * k);
            drive(0, k < 2, ins(b + 8), ins(b + 12), b + 8, 0, 0, 0, 0);
            checks++; if ({bus.issue_valid1, bus.issue_valid2} !== 2'b11) begin errors++; $display("FAIL tp_valids k%0d got %b want 11", k, {bus.issue_valid1, bus.issue_valid2}); end
            checks++; if (bus.issue_pc1 !== b || bus.issue_pc2 !== b + 4) begin errors++; $display("FAIL tp_pcs k%0d got %h/%h want %h/%h", k, bus.issue_pc1, bus.issue_pc2, b, b + 4); end
            checks++; if (bus.issue_instr1 !== ins(b) || bus.issue_instr2 !== ins(b + 4)) begin errors++; $display("FAIL tp_instr k%0d got %h/%h want %h/%h", k, bus.issue_instr1, bus.issue_instr2, ins(b), ins(b + 4)); end
            tick();
        end
        idle();
        checks++; if (bus.issue_valid1 !== 1'b0) begin errors++; $display("FAIL tp_drained_v1 got %b want 0", bus.issue_valid1); end
        checks++; if (bus.issued_cnt !== 32'd6) begin errors++; $display("FAIL tp_issued got %0d want 6", bus.issued_cnt); end
        checks++; if (bus.single_cnt !== 32'd0) begin errors++; $display("FAIL tp_single got %0d want 0", bus.single_cnt); end
        tick();
    endtask

    task automatic test_conflict();
        do_reset();
        drive(0, 1, ins(0), ins(4), 32'h0, 0, 0, 0, 0);
        tick();
        drive(0, 1, ins(8), ins(12), 32'h8, 0, 0, 1, 0);
        checks++; if ({bus.issue_valid1, bus.issue_valid2} !== 2'b10 || bus.issue_pc1 !== 32'h0) begin errors++; $display("FAIL cf_single got v%b%b pc %h want v10 pc 0", bus.issue_valid1, bus.issue_valid2, bus.issue_pc1); end
        tick();
        idle();
        checks++; if ({bus.issue_valid1, bus.issue_valid2} !== 2'b11 || bus.issue_pc1 !== 32'h4 || bus.issue_pc2 !== 32'h8) begin errors++; $display("FAIL cf_pair got v%b%b pc %h/%h want v11 pc 4/8", bus.issue_valid1, bus.issue_valid2, bus.issue_pc1, bus.issue_pc2); end
        checks++; if (bus.single_cnt !== 32'd1) begin errors++; $display("FAIL cf_single_cnt got %0d want 1", bus.single_cnt); end
        tick();
        idle();
        checks++; if ({bus.issue_valid1, bus.issue_valid2} !== 2'b10 || bus.issue_pc1 !== 32'hC) begin errors++; $display("FAIL cf_count1 got v%b%b pc %h want v10 pc c", bus.issue_valid1, bus.issue_valid2, bus.issue_pc1); end
        tick();
        idle();
        checks++; if (bus.issued_cnt !== 32'd4 || bus.single_cnt !== 32'd2) begin errors++; $display("FAIL cf_counts got %0d/%0d want 4/2", bus.issued_cnt, bus.single_cnt); end
        tick();
    endtask

    task automatic test_fill_wrap();
        logic [31:0] p;
        do_reset();
        drive(0, 1, ins(0), ins(4), 32'h0, 0, 0, 0, 0);
        tick();
        idle();
        tick();
        for (int k = 0; k < 4; k++) begin
            p = 32'h100 + 32'(8 * k);
            drive(0, 1, ins(p), ins(p + 4), p, 0, 1, 0, 0);
            checks++; if (bus.fetch_ready !== (k < 2)) begin errors++; $display("FAIL fill_ready k%0d got %b want %b", k, bus.fetch_ready, k < 2); end
            checks++; if (bus.issue_valid1 !== 1'b0) begin errors++; $display("FAIL fill_stall_v1 k%0d got %b want 0", k, bus.issue_valid1); end
            tick();
        end
        drive(0, 0, '0, '0, '0, 0, 0, 1, 0);
        checks++; if ({bus.issue_valid1, bus.issue_valid2} !== 2'b10 || bus.issue_pc1 !== 32'h100) begin errors++; $display("FAIL wrap_a got v%b%b pc %h want v10 pc 100", bus.issue_valid1, bus.issue_valid2, bus.issue_pc1); end
        tick();
        drive(0, 1, ins(32'h200), ins(32'h204), 32'h200, 0, 0, 0, 0);
        checks++; if (bus.fetch_ready !== 1'b0) begin errors++; $display("FAIL wrap_count3_ready got %b want 0", bus.fetch_ready); end
        checks++; if ({bus.issue_valid1, bus.issue_valid2} !== 2'b11 || bus.issue_pc1 !== 32'h104 || bus.issue_pc2 !== 32'h108) begin errors++; $display("FAIL wrap_b got v%b%b pc %h/%h want v11 pc 104/108", bus.issue_valid1, bus.issue_valid2, bus.issue_pc1, bus.issue_pc2); end
        tick();
        idle();
        checks++; if ({bus.issue_valid1, bus.issue_valid2} !== 2'b10 || bus.issue_pc1 !== 32'h10C || bus.issue_instr1 !== ins(32'h10C)) begin errors++; $display("FAIL wrap_c got v%b%b pc %h want v10 pc 10c", bus.issue_valid1, bus.issue_valid2, bus.issue_pc1); end
        tick();
        idle();
        checks++; if (bus.issue_valid1 !== 1'b0 || bus.issued_cnt !== 32'd6 || bus.single_cnt !== 32'd2) begin errors++; $display("FAIL wrap_end got v%b cnt %0d/%0d want v0 cnt 6/2", bus.issue_valid1, bus.issued_cnt, bus.single_cnt); end
        tick();
    endtask

    task automatic test_flush();
        do_reset();
        drive(0, 1, ins(0), ins(4), 32'h0, 0, 1, 0, 0);
        tick();
        drive(0, 1, ins(8), ins(12), 32'h8, 0, 0, 1, 0);
        tick();
        drive(0, 1, ins(32'h10), ins(32'h14), 32'h10, 1, 0, 0, 0);
        checks++; if ({bus.issue_valid1, bus.issue_valid2, bus.fetch_ready} !== 3'b000) begin errors++; $display("FAIL flush_cycle got v%b%b r%b want 000", bus.issue_valid1, bus.issue_valid2, bus.fetch_ready); end
        tick();
        idle();
        checks++; if (bus.issue_valid1 !== 1'b0 || bus.fetch_ready !== 1'b1) begin errors++; $display("FAIL flush_after got v%b r%b want v0 r1", bus.issue_valid1, bus.fetch_ready); end
        checks++; if (bus.issued_cnt !== 32'd1 || bus.single_cnt !== 32'd1) begin errors++; $display("FAIL flush_counts got %0d/%0d want 1/1", bus.issued_cnt, bus.single_cnt); end
        tick();
    endtask

    task automatic test_halt();
        do_reset();
        drive(0, 1, HALT_OP, ins(32'h24), 32'h20, 0, 0, 0, 0);
        tick();
        drive(0, 0, '0, '0, '0, 0, 0, 0, 1);
        checks++; if ({bus.issue_valid1, bus.issue_valid2} !== 2'b10 || bus.issue_pc1 !== 32'h20 || bus.issue_instr1 !== HALT_OP) begin errors++; $display("FAIL halt_issue got v%b%b pc %h want v10 pc 20", bus.issue_valid1, bus.issue_valid2, bus.issue_pc1); end
        tick();
        for (int k = 0; k < 3; k++) begin
            drive(0, 1, ins(32'h40), ins(32'h44), 32'h40, k == 1, 0, 0, 0);
            checks++; if ({bus.halted, bus.issue_valid1, bus.issue_valid2, bus.fetch_ready} !== 4'b1000) begin errors++; $display("FAIL halt_frozen k%0d got h%b v%b%b r%b want h1 v00 r0", k, bus.halted, bus.issue_valid1, bus.issue_valid2, bus.fetch_ready); end
            checks++; if (bus.issued_cnt !== 32'd1 || bus.single_cnt !== 32'd1) begin errors++; $display("FAIL halt_counts k%0d got %0d/%0d want 1/1", k, bus.issued_cnt, bus.single_cnt); end
            tick();
        end
        drive(1, 0, '0, '0, '0, 0, 0, 0, 0);
        checks++; if (bus.halted !== 1'b0 || bus.issued_cnt !== 32'd0) begin errors++; $display("FAIL halt_rst got h%b cnt %0d want h0 cnt 0", bus.halted, bus.issued_cnt); end
        tick();
        idle();
        checks++; if (bus.halted !== 1'b0 || bus.fetch_ready !== 1'b1 || bus.single_cnt !== 32'd0) begin errors++; $display("FAIL halt_rerun got h%b r%b s%0d want h0 r1 s0", bus.halted, bus.fetch_ready, bus.single_cnt); end
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        drive(0, 1, ins(32'h40), ins(32'h44), 32'h40, 0, 0, 0, 0);
        tick();
        drive(1, 1, ins(32'h48), ins(32'h4C), 32'h48, 0, 0, 0, 0);
        checks++; if ({bus.issue_valid1, bus.issue_valid2, bus.fetch_ready, bus.halted} !== 4'b0000) begin errors++; $display("FAIL rstmid_outs got v%b%b r%b h%b want 0000", bus.issue_valid1, bus.issue_valid2, bus.fetch_ready, bus.halted); end
        tick();
        idle();
        checks++; if (bus.issue_valid1 !== 1'b0 || bus.fetch_ready !== 1'b1) begin errors++; $display("FAIL rstmid_after got v%b r%b want v0 r1", bus.issue_valid1, bus.fetch_ready); end
        tick();
    endtask

    task automatic test_random();
        logic [31:0] i1, i2, pc;
        logic        h;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            i1 = $urandom();
            i2 = $urandom();
            if (i1 == HALT_OP) i1 = i1 ^ 32'h1;
            if (i2 == HALT_OP) i2 = i2 ^ 32'h1;
            if ($urandom_range(0, 47) == 0) i1 = HALT_OP;
            pc = $urandom() & 32'hFFFF_FFF8;
            h  = (mq.size() >= 1) ? (mq[0].instr == HALT_OP) : 1'b0;
            drive($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0, i1, i2, pc,
                  $urandom_range(0, 15) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 2) == 0, h);
            checks++; if (bus.fetch_ready !== exp_ready) begin errors++; $display("FAIL rand_ready c%0d got %b want %b", c, bus.fetch_ready, exp_ready); end
            checks++; if (bus.issue_valid1 !== exp_v1) begin errors++; $display("FAIL rand_v1 c%0d got %b want %b", c, bus.issue_valid1, exp_v1); end
            checks++; if (bus.issue_valid2 !== exp_v2) begin errors++; $display("FAIL rand_v2 c%0d got %b want %b", c, bus.issue_valid2, exp_v2); end
            checks++; if (bus.halted !== (m_halted && !rst_i)) begin errors++; $display("FAIL rand_halted c%0d got %b want %b", c, bus.halted, m_halted && !rst_i); end
            checks++; if (bus.issued_cnt !== (rst_i ? 32'd0 : m_issued)) begin errors++; $display("FAIL rand_issued c%0d got %0d want %0d", c, bus.issued_cnt, rst_i ? 32'd0 : m_issued); end
            checks++; if (bus.single_cnt !== (rst_i ? 32'd0 : m_single)) begin errors++; $display("FAIL rand_single c%0d got %0d want %0d", c, bus.single_cnt, rst_i ? 32'd0 : m_single); end
            if (!rst_i && mq.size() >= 1) begin
                checks++; if (bus.issue_instr1 !== mq[0].instr || bus.issue_pc1 !== mq[0].pc) begin errors++; $display("FAIL rand_slot1 c%0d got %h@%h want %h@%h", c, bus.issue_instr1, bus.issue_pc1, mq[0].instr, mq[0].pc); end
            end
            if (!rst_i && mq.size() >= 2) begin
                checks++; if (bus.issue_instr2 !== mq[1].instr || bus.issue_pc2 !== mq[1].pc) begin errors++; $display("FAIL rand_slot2 c%0d got %h@%h want %h@%h", c, bus.issue_instr2, bus.issue_pc2, mq[1].instr, mq[1].pc); end
            end
            tick();
        end
    endtask

    initial begin
        drive(1, 0, '0, '0, '0, 0, 0, 0, 0);
        @(negedge clk_i);
        test_reset();
        test_throughput();
        test_conflict();
        test_fill_wrap();
        test_flush();
        test_halt();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
